// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: datapath width, ALU
// operation and branch-compare codes, and the result-slot state encoding.
package alu_arbiter_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] ALU_CTRL_ADD  = 4'd0;
    localparam logic [3:0] ALU_CTRL_SUB  = 4'd1;
    localparam logic [3:0] ALU_CTRL_AND  = 4'd2;
    localparam logic [3:0] ALU_CTRL_OR   = 4'd3;
    localparam logic [3:0] ALU_CTRL_XOR  = 4'd4;
    localparam logic [3:0] ALU_CTRL_SLL  = 4'd5;
    localparam logic [3:0] ALU_CTRL_SRL  = 4'd6;
    localparam logic [3:0] ALU_CTRL_SRA  = 4'd7;
    localparam logic [3:0] ALU_CTRL_SLT  = 4'd8;
    localparam logic [3:0] ALU_CTRL_SLTU = 4'd9;
    localparam logic [3:0] ALU_CTRL_LUI  = 4'd10;

    // Branch-compare codes; ALU_BNONE selects the plain ALU result.
    localparam logic [2:0] ALU_BNONE = 3'd0;
    localparam logic [2:0] ALU_BEQ   = 3'd1;
    localparam logic [2:0] ALU_BNE   = 3'd2;
    localparam logic [2:0] ALU_BLT   = 3'd3;
    localparam logic [2:0] ALU_BGE   = 3'd4;
    localparam logic [2:0] ALU_BLTU  = 3'd5;
    localparam logic [2:0] ALU_BGEU  = 3'd6;

    typedef enum logic {
        ARB_EMPTY = 1'b0,
        ARB_FULL  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester channels and the result channel of alu_arbiter.
// The master side is the requesters/consumer; the slave side is the arbiter.
interface alu_arbiter_if #(
    parameter int XLEN = alu_arbiter_pkg::XLEN
);
    logic            r0_valid;
    logic            r0_ready;
    logic [XLEN-1:0] r0_a;
    logic [XLEN-1:0] r0_b;
    logic [3:0]      r0_aluctrl;
    logic [2:0]      r0_aluctrl1;

    logic            r1_valid;
    logic            r1_ready;
    logic [XLEN-1:0] r1_a;
    logic [XLEN-1:0] r1_b;
    logic [3:0]      r1_aluctrl;
    logic [2:0]      r1_aluctrl1;

    logic            res_valid;
    logic            res_ready;
    logic [XLEN-1:0] res_data;
    logic            res_src;

    modport master (
        output r0_valid, r0_a, r0_b, r0_aluctrl, r0_aluctrl1,
        output r1_valid, r1_a, r1_b, r1_aluctrl, r1_aluctrl1,
        output res_ready,
        input  r0_ready, r1_ready, res_valid, res_data, res_src
    );

    modport slave (
        input  r0_valid, r0_a, r0_b, r0_aluctrl, r0_aluctrl1,
        input  r1_valid, r1_a, r1_b, r1_aluctrl, r1_aluctrl1,
        input  res_ready,
        output r0_ready, r1_ready, res_valid, res_data, res_src
    );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Purely combinational ALU: arithmetic/logic result per aluctrl, or a 0/1
// branch-compare result when aluctrl1 is nonzero. Unknown codes give 0.
module alu_arbiter_alu #(
    parameter int XLEN = alu_arbiter_pkg::XLEN
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [3:0]      aluctrl_i,
    input  logic [2:0]      aluctrl1_i,
    output logic [XLEN-1:0] y_o
);
    import alu_arbiter_pkg::*;

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0]  shamt;
    logic            eq;
    logic            lt_s;
    logic            lt_u;
    logic            cmp;
    logic [XLEN-1:0] op_res;

    assign shamt = b_i[SHW-1:0];
    assign eq    = (a_i == b_i);
    assign lt_s  = ($signed(a_i) < $signed(b_i));
    assign lt_u  = (a_i < b_i);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        op_res = '0;
        case (aluctrl_i)
            ALU_CTRL_ADD:  op_res = a_i + b_i;
            ALU_CTRL_SUB:  op_res = a_i - b_i;
            ALU_CTRL_AND:  op_res = a_i & b_i;
            ALU_CTRL_OR:   op_res = a_i | b_i;
            ALU_CTRL_XOR:  op_res = a_i ^ b_i;
            ALU_CTRL_SLL:  op_res = a_i << shamt;
            ALU_CTRL_SRL:  op_res = a_i >> shamt;
            ALU_CTRL_SRA:  op_res = $unsigned($signed(a_i) >>> shamt);
            ALU_CTRL_SLT:  op_res = {{(XLEN-1){1'b0}}, lt_s};
            ALU_CTRL_SLTU: op_res = {{(XLEN-1){1'b0}}, lt_u};
            ALU_CTRL_LUI:  op_res = b_i;
            default:       op_res = '0;
        endcase
    end

    always_comb begin
        cmp = 1'b0;
        case (aluctrl1_i)
            ALU_BEQ:  cmp = eq;
            ALU_BNE:  cmp = !eq;
            ALU_BLT:  cmp = lt_s;
            ALU_BGE:  cmp = !lt_s;
            ALU_BLTU: cmp = lt_u;
            ALU_BGEU: cmp = !lt_u;
            default:  cmp = 1'b0;
        endcase
    end

    assign y_o = (aluctrl1_i != ALU_BNONE) ? {{(XLEN-1){1'b0}}, cmp} : op_res;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters through a one-entry result slot.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise r0 has fixed priority.
module alu_arbiter #(
    parameter int XLEN = alu_arbiter_pkg::XLEN
) (
    input  logic          clk,
    input  logic          rstn,
    alu_arbiter_if.slave  bus
);
    import alu_arbiter_pkg::*;

    arb_state_e      state_q, state_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [3:0]      ctrl_q, ctrl_d;
    logic [2:0]      ctrl1_q, ctrl1_d;
    logic            src_q, src_d;

    logic            slot_open;
    logic            prefer1;
    logic            grant0;
    logic            grant1;
    logic            accept;
    logic            consume;
    logic [XLEN-1:0] alu_y;

    // Gating with rstn keeps both readies low while reset is held.
    assign slot_open = rstn && ((state_q == ARB_EMPTY) || bus.res_ready);
    assign consume   = (state_q == ARB_FULL) && bus.res_ready;
    assign accept    = grant0 || grant1;

`ifdef ALU_ARB_RR_EN
    logic ptr_q, ptr_d;

    // The requester just granted loses priority for the next contested cycle.
    assign prefer1 = ptr_q;
    assign ptr_d   = accept ? grant0 : ptr_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ptr_q <= 1'b0;
        else       ptr_q <= ptr_d;
    end
`else
    assign prefer1 = 1'b0;
`endif

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (slot_open) begin
            if (bus.r0_valid && bus.r1_valid) begin
                grant0 = !prefer1;
                grant1 = prefer1;
            end else begin
                grant0 = bus.r0_valid;
                grant1 = bus.r1_valid;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_EMPTY: if (accept) state_d = ARB_FULL;
            ARB_FULL:  if (consume && !accept) state_d = ARB_EMPTY;
            default:   state_d = ARB_EMPTY;
        endcase
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        ctrl_d  = ctrl_q;
        ctrl1_d = ctrl1_q;
        src_d   = src_q;
        if (accept) begin
            a_d     = grant1 ? bus.r1_a        : bus.r0_a;
            b_d     = grant1 ? bus.r1_b        : bus.r0_b;
            ctrl_d  = grant1 ? bus.r1_aluctrl  : bus.r0_aluctrl;
            ctrl1_d = grant1 ? bus.r1_aluctrl1 : bus.r0_aluctrl1;
            src_d   = grant1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: captured operands are reset too, so res_data reads 0 rather than X in reset.
            state_q <= ARB_EMPTY;
            a_q     <= '0;
            b_q     <= '0;
            ctrl_q  <= '0;
            ctrl1_q <= '0;
            src_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ctrl_q  <= ctrl_d;
            ctrl1_q <= ctrl1_d;
            src_q   <= src_d;
        end
    end

    alu_arbiter_alu #(.XLEN(XLEN)) u_alu (
        .a_i        (a_q),
        .b_i        (b_q),
        .aluctrl_i  (ctrl_q),
        .aluctrl1_i (ctrl1_q),
        .y_o        (alu_y)
    );

    assign bus.r0_ready  = grant0;
    assign bus.r1_ready  = grant1;
    assign bus.res_valid = (state_q == ARB_FULL);
    assign bus.res_data  = alu_y;
    assign bus.res_src   = src_q;

endmodule
